// File: rtl/hdlc_pkg.sv
// rtl/hdlc_pkg.sv - shared constants and state type for the HDLC receive bit path
package hdlc_pkg;

  localparam logic [7:0] HDLC_FLAG       = 8'h7E;
  localparam logic [2:0] HDLC_STUFF_ONES = 3'd5;
  localparam logic [2:0] HDLC_FLAG_ONES  = 3'd6;

  typedef enum logic {RX_IDLE, RX_FRAME} rx_state_t;

endpackage

// File: rtl/hdlc_rx_flagdet.sv
// rtl/hdlc_rx_flagdet.sv - consecutive-ones counter and abort/flag/stuff decode
module hdlc_rx_flagdet
  import hdlc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic rx_en,
  output logic abort_evt,
  output logic flag_evt,
  output logic stuff_evt
);

  logic [2:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (rx_en) begin
      if (!rx) begin
        ones_d = 3'd0;
      end else if (ones_q != 3'd7) begin
        ones_d = ones_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= 3'd0;
    end else begin
      ones_q <= ones_d;
    end
  end

  // Events are decoded on the incoming bit, before the counter updates.
  assign abort_evt = rx_en &&  rx && (ones_q == HDLC_FLAG_ONES);
  assign flag_evt  = rx_en && !rx && (ones_q == HDLC_FLAG_ONES);
  assign stuff_evt = rx_en && !rx && (ones_q == HDLC_STUFF_ONES);

endmodule

// File: rtl/hdlc_rx_bitproc.sv
// rtl/hdlc_rx_bitproc.sv - HDLC receive bit processing: destuffing, byte assembly, frame events
module hdlc_rx_bitproc
  import hdlc_pkg::*;
#(
  parameter int MAX_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxEN,
  output logic       RxD,
  output logic       ZeroDetect,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic       Rx_NewByte,
  output logic [7:0] Rx_Data,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic [7:0] Rx_FrameSize,
  output logic       Rx_AbortSignal,
  output logic       Rx_Overflow
);

  localparam logic [7:0] OVF_AT = 8'(MAX_BYTES);

  logic abort_evt, flag_evt, stuff_evt;

  hdlc_rx_flagdet u_flagdet (
    .clk       (Clk),
    .rst_n     (Rst),
    .rx        (Rx),
    .rx_en     (RxEN),
    .abort_evt (abort_evt),
    .flag_evt  (flag_evt),
    .stuff_evt (stuff_evt)
  );

  rx_state_t  state_q, state_d;
  logic [7:0] dl_q, dl_d, dm_q, dm_d, sh_q, sh_d;
  logic [7:0] data_q, data_d, size_q, size_d, bytecnt_q, bytecnt_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       rxd_q, rxd_d, ferr_q, ferr_d;
  logic       zero_q, zero_d, flag_q, flag_d, adet_q, adet_d, newbyte_q, newbyte_d;
  logic       eof_q, eof_d, asig_q, asig_d, ovf_q, ovf_d;

  always_comb begin
    state_d   = state_q;
    dl_d      = dl_q;
    dm_d      = dm_q;
    sh_d      = sh_q;
    data_d    = data_q;
    size_d    = size_q;
    bytecnt_d = bytecnt_q;
    bitcnt_d  = bitcnt_q;
    rxd_d     = rxd_q;
    ferr_d    = ferr_q;
    zero_d    = 1'b0;
    flag_d    = 1'b0;
    adet_d    = 1'b0;
    newbyte_d = 1'b0;
    eof_d     = 1'b0;
    asig_d    = 1'b0;
    ovf_d     = 1'b0;
    if (RxEN) begin
      rxd_d  = dl_q[7];
      dl_d   = {dl_q[6:0], Rx};
      dm_d   = {dm_q[6:0], stuff_evt};
      zero_d = stuff_evt;
      flag_d = flag_evt;
      adet_d = abort_evt;
      // The bit leaving the delay line is assembled before any flag/abort handling.
      if (state_q == RX_FRAME && !dm_q[7]) begin
        sh_d     = {dl_q[7], sh_q[7:1]};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          data_d    = sh_d;
          newbyte_d = 1'b1;
          ovf_d     = (bytecnt_q == OVF_AT);
          if (bytecnt_q != 8'hFF) begin
            bytecnt_d = bytecnt_q + 8'd1;
          end
        end
      end
      if (flag_evt || abort_evt) begin
        dm_d = 8'hFF;
      end
      if (flag_evt) begin
        if (state_q == RX_FRAME && (bytecnt_d != 8'd0 || bitcnt_d != 3'd0)) begin
          eof_d  = 1'b1;
          size_d = bytecnt_d;
          ferr_d = (bitcnt_d != 3'd0);
        end
        state_d   = RX_FRAME;
        bitcnt_d  = 3'd0;
        bytecnt_d = 8'd0;
      end else if (abort_evt && state_q == RX_FRAME) begin
        asig_d  = 1'b1;
        state_d = RX_IDLE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= RX_IDLE;
      dl_q      <= 8'hFF;
      dm_q      <= 8'hFF;
      sh_q      <= 8'd0;
      data_q    <= 8'd0;
      size_q    <= 8'd0;
      bytecnt_q <= 8'd0;
      bitcnt_q  <= 3'd0;
      rxd_q     <= 1'b0;
      ferr_q    <= 1'b0;
      zero_q    <= 1'b0;
      flag_q    <= 1'b0;
      adet_q    <= 1'b0;
      newbyte_q <= 1'b0;
      eof_q     <= 1'b0;
      asig_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dl_q      <= dl_d;
      dm_q      <= dm_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      size_q    <= size_d;
      bytecnt_q <= bytecnt_d;
      bitcnt_q  <= bitcnt_d;
      rxd_q     <= rxd_d;
      ferr_q    <= ferr_d;
      zero_q    <= zero_d;
      flag_q    <= flag_d;
      adet_q    <= adet_d;
      newbyte_q <= newbyte_d;
      eof_q     <= eof_d;
      asig_q    <= asig_d;
      ovf_q     <= ovf_d;
    end
  end

  assign RxD            = rxd_q;
  assign ZeroDetect     = zero_q;
  assign Rx_FlagDetect  = flag_q;
  assign Rx_AbortDetect = adet_q;
  assign Rx_ValidFrame  = (state_q == RX_FRAME);
  assign Rx_NewByte     = newbyte_q;
  assign Rx_Data        = data_q;
  assign Rx_EoF         = eof_q;
  assign Rx_FrameError  = ferr_q;
  assign Rx_FrameSize   = size_q;
  assign Rx_AbortSignal = asig_q;
  assign Rx_Overflow    = ovf_q;

endmodule

// File: tb/tb_hdlc_rx_bitproc.sv
// tb/tb_hdlc_rx_bitproc.sv - self-checking bench with a byte-level HDLC encoder as reference
module tb_hdlc_rx_bitproc;
  import hdlc_pkg::*;

  localparam int MAX_BYTES = 128;

  logic       Clk = 1'b0, Rst = 1'b0, Rx = 1'b0, RxEN = 1'b0;
  logic       RxD, ZeroDetect, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte;
  logic [7:0] Rx_Data, Rx_FrameSize;
  logic       Rx_EoF, Rx_FrameError, Rx_AbortSignal, Rx_Overflow;

  always #5 Clk = ~Clk;

  hdlc_rx_bitproc #(.MAX_BYTES(MAX_BYTES)) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .RxEN(RxEN), .RxD(RxD), .ZeroDetect(ZeroDetect),
    .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect), .Rx_ValidFrame(Rx_ValidFrame),
    .Rx_NewByte(Rx_NewByte), .Rx_Data(Rx_Data), .Rx_EoF(Rx_EoF), .Rx_FrameError(Rx_FrameError),
    .Rx_FrameSize(Rx_FrameSize), .Rx_AbortSignal(Rx_AbortSignal), .Rx_Overflow(Rx_Overflow)
  );

  int checks = 0, errors = 0;

  // Observed event log, written only by the monitor.
  logic [7:0] obs_bytes[$];
  logic [9:0] obs_eof[$];
  int obs_zero = 0, obs_flag = 0, obs_adet = 0, obs_asig = 0, obs_ovf = 0, ovf_at = -1;

  always @(negedge Clk) begin
    if (Rx_NewByte) obs_bytes.push_back(Rx_Data);
    if (Rx_EoF) obs_eof.push_back({Rx_NewByte, Rx_FrameError, Rx_FrameSize});
    if (ZeroDetect) obs_zero++;
    if (Rx_FlagDetect) obs_flag++;
    if (Rx_AbortDetect) obs_adet++;
    if (Rx_AbortSignal) obs_asig++;
    if (Rx_Overflow) begin
      obs_ovf++;
      ovf_at = obs_bytes.size();
    end
  end

  // Expected event log, built from what the encoder sends.
  logic [7:0] exp_bytes[$];
  logic [9:0] exp_eof[$];
  logic [7:0] frame_q[$];
  bit         sent_bits[$];
  int exp_zero = 0, exp_flag = 0, exp_adet = 0, exp_asig = 0, exp_ovf = 0;
  int stall = 0, enc_ones = 0, nb_idx = 0, ne_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put_bit(input bit b);
    for (int i = 0; i < stall; i++) begin
      @(negedge Clk);
      RxEN = 1'b0;
      Rx   = 1'($urandom);
    end
    @(negedge Clk);
    RxEN = 1'b1;
    Rx   = b;
    sent_bits.push_back(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      RxEN = 1'b0;
      Rx   = 1'($urandom);
    end
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = HDLC_FLAG;
    for (int i = 0; i < 8; i++) put_bit(f[i]);
    enc_ones = 0;
    exp_flag++;
  endtask

  task automatic send_data_bit(input bit b);
    put_bit(b);
    if (b) begin
      enc_ones++;
      if (enc_ones == 5) begin
        put_bit(1'b0);
        enc_ones = 0;
        exp_zero++;
      end
    end else begin
      enc_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_data_bit(v[i]);
    exp_bytes.push_back(v);
  endtask

  task automatic expect_eof(input int n, input bit aligned);
    exp_eof.push_back({aligned, !aligned, 8'(n)});
    if (n > MAX_BYTES) exp_ovf++;
  endtask

  task automatic send_frame();
    send_flag();
    foreach (frame_q[i]) send_byte(frame_q[i]);
    send_flag();
    expect_eof(frame_q.size(), 1'b1);
  endtask

  task automatic verify(input string tag);
    check({tag, "_nbytes"}, 32'(obs_bytes.size()), 32'(exp_bytes.size()));
    for (int i = nb_idx; i < exp_bytes.size() && i < obs_bytes.size(); i++)
      check({tag, "_byte"}, 32'(obs_bytes[i]), 32'(exp_bytes[i]));
    check({tag, "_neof"}, 32'(obs_eof.size()), 32'(exp_eof.size()));
    for (int i = ne_idx; i < exp_eof.size() && i < obs_eof.size(); i++)
      check({tag, "_eof"}, 32'(obs_eof[i]), 32'(exp_eof[i]));
    check({tag, "_zero"}, obs_zero, exp_zero);
    check({tag, "_flags"}, obs_flag, exp_flag);
    check({tag, "_abort_det"}, obs_adet, exp_adet);
    check({tag, "_abort_sig"}, obs_asig, exp_asig);
    check({tag, "_overflow"}, obs_ovf, exp_ovf);
    nb_idx = exp_bytes.size();
    ne_idx = exp_eof.size();
  endtask

  initial begin
    int n, base;
    logic [11:0] mis;

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_outputs", {20'd0, RxD, ZeroDetect, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame,
          Rx_NewByte, Rx_EoF, Rx_FrameError, Rx_AbortSignal, Rx_Overflow, 2'd0}, 32'd0);
    check("rst_data", 32'(Rx_Data), 32'd0);
    check("rst_size", 32'(Rx_FrameSize), 32'd0);
    Rst = 1'b1;
    idle(2);

    // Basic frame with exact-cycle checks at the closing flag
    send_flag();
    check("rxd_prefill", 32'(RxD), 32'd1);
    frame_q = '{8'hA5, 8'h3C};
    foreach (frame_q[i]) send_byte(frame_q[i]);
    send_flag();
    expect_eof(2, 1'b1);
    @(negedge Clk);
    RxEN = 1'b0;
    check("eof_cycle", 32'(Rx_EoF), 32'd1);
    check("newbyte_with_eof", 32'(Rx_NewByte), 32'd1);
    check("rxd_delay8", 32'(RxD), 32'(sent_bits[sent_bits.size() - 9]));
    check("valid_frame", 32'(Rx_ValidFrame), 32'd1);
    @(negedge Clk);
    check("eof_width", 32'(Rx_EoF), 32'd0);
    check("size_held", 32'(Rx_FrameSize), 32'd2);
    idle(2);
    verify("basic");

    // Stuffed zero
    frame_q = '{8'hFF};
    send_frame();
    idle(3);
    verify("stuff");

    // Abort in frame, then abort while idle
    send_flag();
    send_byte(8'h12);
    idle(1);
    check("in_frame", 32'(Rx_ValidFrame), 32'd1);
    send_data_bit(1'b0);
    repeat (7) put_bit(1'b1);
    exp_adet++;
    exp_asig++;
    idle(2);
    check("abort_valid_low", 32'(Rx_ValidFrame), 32'd0);
    put_bit(1'b0);
    repeat (7) put_bit(1'b1);
    exp_adet++;
    idle(2);
    verify("abort");

    // Misaligned frame: 12 data bits
    mis = 12'($urandom);
    send_flag();
    for (int i = 0; i < 12; i++) send_data_bit(mis[i]);
    exp_bytes.push_back(mis[7:0]);
    send_flag();
    expect_eof(1, 1'b0);
    idle(3);
    verify("misaligned");

    // Flag sharing with idle flags
    send_flag();
    send_flag();
    send_flag();
    send_byte(8'h55);
    send_flag();
    expect_eof(1, 1'b1);
    send_byte(8'hAA);
    send_flag();
    expect_eof(1, 1'b1);
    idle(3);
    verify("share");

    // Random frames with random stall gaps
    for (int f = 0; f < 6; f++) begin
      stall = $urandom_range(0, 2);
      n = $urandom_range(1, 6);
      frame_q = {};
      for (int i = 0; i < n; i++)
        frame_q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      send_frame();
      idle(2);
    end
    stall = 0;
    verify("random");

    // Overflow
    base = exp_bytes.size();
    frame_q = {};
    for (int i = 0; i < 130; i++) frame_q.push_back(8'($urandom));
    send_frame();
    idle(3);
    check("ovf_on_byte129", ovf_at, base + MAX_BYTES + 1);
    verify("overflow");

    // RxEN one-in-three
    stall = 2;
    frame_q = '{8'hA5, 8'h3C};
    send_frame();
    idle(3);
    stall = 0;
    verify("stall");

    // Reset mid-frame drops the frame
    send_flag();
    send_byte(8'h5A);
    void'(exp_bytes.pop_back());
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    idle(2);
    check("pre_reset_valid", 32'(Rx_ValidFrame), 32'd1);
    Rst = 1'b0;
    #1;
    check("mid_rst_outputs", {20'd0, RxD, ZeroDetect, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame,
          Rx_NewByte, Rx_EoF, Rx_FrameError, Rx_AbortSignal, Rx_Overflow, 2'd0}, 32'd0);
    check("mid_rst_data", 32'(Rx_Data), 32'd0);
    check("mid_rst_size", 32'(Rx_FrameSize), 32'd0);
    idle(2);
    Rst = 1'b1;
    idle(2);
    frame_q = '{8'hC3};
    send_frame();
    idle(3);
    verify("reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_bitproc.md
# hdlc_rx_bitproc

Bit-level front end of the HDLC receive path. Samples the serial `Rx` line on `RxEN` strobes and detects flags (0x7E), aborts (seven 1s) and inserted zeros. Removes stuffed zeros and assembles LSB-first bytes. Feeds the RX controller/buffer with `Rx_NewByte`/`Rx_Data` and frame-boundary events (`Rx_ValidFrame`, `Rx_EoF`, `Rx_FrameError`, `Rx_AbortSignal`, `Rx_Overflow`).

## Interface
Parameters:
- `MAX_BYTES`, 128: byte count at which overflow is declared; matches RX buffer depth.

Ports:
- `Clk` in 1: single clock; all logic on rising edge.
- `Rst` in 1: asynchronous, active-low reset.
- `Rx` in 1: serial receive bit.
- `RxEN` in 1: sample strobe. State advances only when 1.
- `RxD` out 1: raw bit delayed by 8 samples (`dl[7]`).
- `ZeroDetect` out 1: pulse; stuffed zero removed.
- `Rx_FlagDetect` out 1: pulse; flag completed.
- `Rx_AbortDetect` out 1: pulse; abort pattern seen (any state).
- `Rx_ValidFrame` out 1: level; inside a frame.
- `Rx_NewByte` out 1: pulse; `Rx_Data` holds a new byte.
- `Rx_Data` out 8: assembled byte; held until the next byte.
- `Rx_EoF` out 1: pulse; closing flag of a non-empty frame.
- `Rx_FrameError` out 1: valid with `Rx_EoF`; the frame is not byte-aligned.
- `Rx_FrameSize` out 8: byte count of the frame; valid with `Rx_EoF`, held until the next frame.
- `Rx_AbortSignal` out 1: pulse; abort while `Rx_ValidFrame` = 1.
- `Rx_Overflow` out 1: pulse; byte number `MAX_BYTES`+1 received.

## Operation
- **Ones counter `ones[2:0]`**
  - Incoming 1: increment, saturating at 7.
  - Incoming 0: clear to 0.
- **Events decoded on the incoming bit (priority order)**
  - Abort: incoming 1 with `ones`==6.
  - Flag: incoming 0 with `ones`==6.
  - Stuff: incoming 0 with `ones`==5.
- **Delay line `dl[7:0]` with drop marks `dm[7:0]`**
  - Each sample shifts the incoming bit into `dl[0]`.
  - Its drop mark is 1 on a stuff event.
  - The exiting pair (`dl[7]`, `dm[7]`) feeds the assembler.
- **Flag or abort event:** the exiting bit is processed first. Then all 8 `dm` entries, including the new one, are set to 1, which purges the flag/abort bits.
- **Assembler** (active only in FRAME, and only when the exiting `dm`=0)
  - Shift: `sh = {bit, sh[7:1]}`.
  - `bitcnt` increments; on reaching 8 it wraps to 0, `Rx_Data` <= new `sh`, `Rx_NewByte` pulses and `bytecnt` increments (saturating at 255).
- **States: IDLE, FRAME**
  - IDLE + flag → FRAME; clear `bitcnt` and `bytecnt`.
  - FRAME + flag with `bytecnt`==0 and `bitcnt`==0 (back-to-back flags) → stay in FRAME, no `Rx_EoF`.
  - FRAME + flag, otherwise → `Rx_EoF`. `Rx_FrameSize`=`bytecnt`. `Rx_FrameError`=(`bitcnt`!=0). Stay in FRAME with counters cleared, so a shared flag opens the next frame.
  - FRAME + abort → `Rx_AbortSignal`, go to IDLE, no `Rx_EoF`.
  - IDLE + abort → `Rx_AbortDetect` only.
- **Overflow:** when `bytecnt` goes from `MAX_BYTES` to `MAX_BYTES`+1, pulse `Rx_Overflow` once per frame. Reception continues.

## Timing
- All outputs are registered. Pulses last exactly one `Clk` cycle, in the cycle after the deciding sample, even if `RxEN` drops.
- With `RxEN`=0, all state and the held outputs are frozen.
- Latency: raw data bit at sample N reaches the assembler at sample N+8. `Rx_NewByte` follows 1 cycle later.
- Flag/abort/overflow/stuff pulses appear 1 cycle after the completing sample.
- Same sample with a byte completion and a flag: `Rx_NewByte` and `Rx_EoF` are asserted in the same cycle, and `Rx_FrameSize` includes that byte.
- Reset values:
  - `dl` = 0xFF, `dm` = 0xFF, `ones` = 0, state = IDLE.
  - All pulses and `Rx_ValidFrame` = 0; `Rx_Data`, `Rx_FrameSize` and `RxD` = 0 (`RxD` shows `dl[7]` from the first sample after reset).
- Reset mid-frame drops the frame silently: no `Rx_EoF`, no `Rx_AbortSignal`.

## Structure
- Package `hdlc_pkg`:
  - `HDLC_FLAG` = 8'h7E, `HDLC_STUFF_ONES` = 5, `HDLC_FLAG_ONES` = 6.
  - `typedef enum logic {RX_IDLE, RX_FRAME} rx_state_t`.
- Sub-module `hdlc_rx_flagdet`: ones counter and abort/flag/stuff event decode. The parent holds the delay line, assembler, FSM and counters.

## Test plan
- **Basic frame:** 7E, 0xA5, 0x3C, 7E (LSB first, `RxEN`=1 every cycle) → `Rx_NewByte` ×2 with `Rx_Data` 0xA5 then 0x3C. `Rx_EoF` with `Rx_FrameSize`=2, `Rx_FrameError`=0.
- **Stuffed zero:** 7E, raw bits 1,1,1,1,1,0,1,1,1 (data 0xFF), 7E → one `ZeroDetect`. `Rx_Data`=0xFF. `Rx_FrameSize`=1.
- **Abort:** 7E, 0x12, then seven 1s → `Rx_NewByte` (0x12), then `Rx_AbortDetect` + `Rx_AbortSignal`. `Rx_ValidFrame` falls. No `Rx_EoF`.
- **Misaligned frame:** 7E, 12 data bits, 7E → one `Rx_NewByte`. `Rx_EoF` with `Rx_FrameError`=1, `Rx_FrameSize`=1.
- **Flag sharing:** 7E 7E 7E, 0x55, 7E, 0xAA, 7E → no `Rx_EoF` for the idle flags. Two `Rx_EoF` pulses, each with size 1.
- **Overflow, stall, reset:**
  - 130 bytes in one frame → single `Rx_Overflow` on byte 129; `Rx_FrameSize`=130.
  - `RxEN` toggling 1-of-3 → identical data.
  - `Rst` low mid-frame → all outputs return to reset values.
